sreg_sched: RTL

Sequencer and two-port arbiter for the parallel-load shift register (`sreg`). It accepts parallel words from two requesters over valid/ready handshakes and grants one at a time. It drives the register's `pl`/`en`/`din` to load the granted word and shift it out over `n` enabled cycles. It also produces sideband flags (`out_valid`, `out_id`, `out_last`) aligned with the register's `so` output. It sits between word-level producers and the serial datapath, sharing one `sreg` instance.

---
 rtl/sreg_sched.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sreg_sched.sv
// sreg_sched: two-requester arbiter and load/shift sequencer driving a parallel-load shift register.
// Define SREG_SCHED_RR_EN for round-robin arbitration; the default build uses fixed priority (requester 0).
module sreg_sched #(
    parameter int n     = 4,
    parameter int width = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*n*width-1:0] req_data,
    input  logic                 hold,
    output logic                 pl,
    output logic                 en,
    output logic [n*width-1:0]   din,
    output logic                 out_valid,
    output logic                 out_id,
    output logic                 out_last,
    output logic                 busy
);
    localparam int ww = n * width;
    localparam int cw = (n > 1) ? $clog2(n) : 1;
    localparam logic [cw-1:0] cnt_last = cw'(n - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t          state_r;
    logic [cw-1:0]   cnt_r;
    logic            grant_r;
    logic [ww-1:0]   din_r;

    logic            en_s;
    logic            last_s;
    logic            accept_s;
    logic            winner_s;
    logic [ww-1:0]   word_s;

`ifdef SREG_SCHED_RR_EN
    logic ptr_r;

    function automatic logic pick_winner(input logic [1:0] v, input logic ptr);
        logic w;
        if (v[ptr]) begin
            w = ptr;
        end else begin
            w = ~ptr;
        end
        return w;
    endfunction
`else
    function automatic logic pick_winner(input logic [1:0] v);
        logic w;
        if (v[0]) begin
            w = 1'b0;
        end else if (v[1]) begin
            w = 1'b1;
        end else begin
            w = 1'b0;
        end
        return w;
    endfunction
`endif

    // Shift enable, last-symbol detect, arbitration window and winner selection.
    always_comb begin
        en_s      = 1'b0;
        last_s    = 1'b0;
        accept_s  = 1'b0;
        winner_s  = 1'b0;
        req_ready = 2'b00;
        word_s    = req_data[ww-1:0];
        if ((state_r == SHIFT) && !hold) begin
            en_s   = 1'b1;
            last_s = (cnt_r == cnt_last);
        end else begin
            en_s   = 1'b0;
            last_s = 1'b0;
        end
        // A new word may be taken when idle or in the final enabled shift cycle.
        if (rstn && (req_valid != 2'b00) && ((state_r == IDLE) || last_s)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
`ifdef SREG_SCHED_RR_EN
        winner_s = pick_winner(req_valid, ptr_r);
`else
        winner_s = pick_winner(req_valid);
`endif
        if (winner_s) begin
            word_s = req_data[2*ww-1:ww];
        end else begin
            word_s = req_data[ww-1:0];
        end
        if (accept_s) begin
            req_ready = winner_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
    end

    assign pl   = (state_r == LOAD);
    assign en   = en_s;
    assign busy = (state_r != IDLE);
    assign din  = din_r;

    // Main sequencer: capture on acceptance, one load cycle, then n enabled shifts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            grant_r <= 1'b0;
            din_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= LOAD;
                        din_r   <= word_s;
                        grant_r <= winner_s;
                    end
                end
                LOAD: begin
                    state_r <= SHIFT;
                    cnt_r   <= '0;
                end
                SHIFT: begin
                    if (en_s) begin
                        if (last_s) begin
                            cnt_r <= '0;
                            if (accept_s) begin
                                state_r <= LOAD;
                                din_r   <= word_s;
                                grant_r <= winner_s;
                            end else begin
                                state_r <= IDLE;
                            end
                        end else begin
                            cnt_r <= cnt_r + cw'(1);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

`ifdef SREG_SCHED_RR_EN
    // Round-robin pointer: after each grant the other requester becomes preferred.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r <= 1'b0;
        end else if (accept_s) begin
            ptr_r <= ~winner_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`endif

    // Sideband flags lag en by one cycle so they line up with the register's so output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_id    <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= en_s;
            out_last  <= last_s;
            if (en_s) begin
                out_id <= grant_r;
            end
        end
    end

endmodule
